// File: rtl/main_fsm_pkg.sv
// Shared control definitions for the multicycle RISC-V controller:
// FSM state encodings, the decoded opcodes and the ALU-decoder operation codes.
package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

endpackage

// File: rtl/main_fsm.sv
// Multicycle controller main FSM: one state register, combinational next-state
// logic and Moore-style control outputs (FETCH strobes gated by mem_ready).
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_update,
    output logic       branch,
    output logic       reg_write,
    output logic       mem_write,
    output logic [3:0] state
);

    state_t state_q, state_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_op     = ALU_OP_ADD;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        if (reset) begin
            // Hold the FETCH datapath setup but suppress every write strobe.
            alu_src_b  = 2'b10;
            result_src = 2'b10;
        end else begin
            case (state_q)
                S_FETCH: begin
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_update  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMREAD:  adr_src = 1'b1;
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECUTER: begin
                    alu_src_a = 2'b10;
                    alu_op    = ALU_OP_FUNCT;
                end
                S_EXECUTEI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = ALU_OP_FUNCT;
                end
                S_ALUWB:    reg_write = 1'b1;
                S_BEQ: begin
                    alu_src_a = 2'b10;
                    alu_op    = ALU_OP_SUB;
                    branch    = 1'b1;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_update = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed, table-driven bench for main_fsm: each row gives the inputs for one
// cycle and the state/control word expected during that cycle.
module tb_main_fsm;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
    } ctrl_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       mr;
        logic [3:0] st;
        ctrl_t      ctrl;
    } vec_t;

    //                                alu   a      b      rs    adr ir pc br rw mw
    localparam ctrl_t C_RST    = '{2'b00, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0};
    localparam ctrl_t C_FETCH0 = '{2'b00, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0};
    localparam ctrl_t C_FETCH1 = '{2'b00, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0};
    localparam ctrl_t C_DECODE = '{2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0};
    localparam ctrl_t C_MEMADR = '{2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0};
    localparam ctrl_t C_MEMRD  = '{2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0};
    localparam ctrl_t C_MEMWB  = '{2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 1, 0};
    localparam ctrl_t C_MEMWR  = '{2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 1};
    localparam ctrl_t C_EXR    = '{2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0};
    localparam ctrl_t C_EXI    = '{2'b10, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0};
    localparam ctrl_t C_ALUWB  = '{2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0};
    localparam ctrl_t C_BEQ    = '{2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0};
    localparam ctrl_t C_JAL    = '{2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 0};

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       mem_ready;
    logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;
    logic       adr_src, ir_write, pc_update, branch, reg_write, mem_write;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    main_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_update  (pc_update),
        .branch     (branch),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ctrl_t got_ctrl();
        return {alu_op, alu_src_a, alu_src_b, result_src, adr_src,
                ir_write, pc_update, branch, reg_write, mem_write};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [6:0] o, input logic mr,
                       input logic [3:0] st, input ctrl_t c);
        vec_t v;
        v.rst = rst; v.op = o; v.mr = mr; v.st = st; v.ctrl = c;
        vecs.push_back(v);
    endtask

    // Inputs change mid-low-phase; outputs are sampled 2ns later, well before
    // the next rising edge, then the bench waits for the following falling edge.
    task automatic drive(input logic rst, input logic [6:0] o, input logic mr);
        reset = rst; op = o; mem_ready = mr;
        #2;
    endtask

    initial begin
        reset = 1'b1; op = BAD; mem_ready = 1'b0;
        @(negedge clk);

        add(1, BAD, 0, 4'd0,  C_RST);
        // lw, no stalls: 0,1,2,3,4
        add(0, LW,  1, 4'd0,  C_FETCH1);
        add(0, LW,  1, 4'd1,  C_DECODE);
        add(0, LW,  1, 4'd2,  C_MEMADR);
        add(0, LW,  1, 4'd3,  C_MEMRD);
        add(0, LW,  1, 4'd4,  C_MEMWB);
        // sw with three stall cycles in MEMWRITE
        add(0, SW,  1, 4'd0,  C_FETCH1);
        add(0, SW,  1, 4'd1,  C_DECODE);
        add(0, SW,  1, 4'd2,  C_MEMADR);
        add(0, SW,  0, 4'd5,  C_MEMWR);
        add(0, SW,  0, 4'd5,  C_MEMWR);
        add(0, SW,  0, 4'd5,  C_MEMWR);
        add(0, SW,  1, 4'd5,  C_MEMWR);
        // beq
        add(0, BQ,  1, 4'd0,  C_FETCH1);
        add(0, BQ,  1, 4'd1,  C_DECODE);
        add(0, BQ,  1, 4'd9,  C_BEQ);
        // unknown opcode behaves as a NOP
        add(0, BAD, 1, 4'd0,  C_FETCH1);
        add(0, BAD, 1, 4'd1,  C_DECODE);
        // fetch stall then R-type
        add(0, RT,  0, 4'd0,  C_FETCH0);
        add(0, RT,  0, 4'd0,  C_FETCH0);
        add(0, RT,  1, 4'd0,  C_FETCH1);
        add(0, RT,  1, 4'd1,  C_DECODE);
        add(0, RT,  1, 4'd6,  C_EXR);
        add(0, RT,  1, 4'd8,  C_ALUWB);
        // I-type
        add(0, IT,  1, 4'd0,  C_FETCH1);
        add(0, IT,  1, 4'd1,  C_DECODE);
        add(0, IT,  1, 4'd7,  C_EXI);
        add(0, IT,  1, 4'd8,  C_ALUWB);
        // jal
        add(0, JL,  1, 4'd0,  C_FETCH1);
        add(0, JL,  1, 4'd1,  C_DECODE);
        add(0, JL,  1, 4'd10, C_JAL);
        add(0, JL,  1, 4'd8,  C_ALUWB);
        // lw with one stall in MEMREAD
        add(0, LW,  1, 4'd0,  C_FETCH1);
        add(0, LW,  1, 4'd1,  C_DECODE);
        add(0, LW,  1, 4'd2,  C_MEMADR);
        add(0, LW,  0, 4'd3,  C_MEMRD);
        add(0, LW,  1, 4'd3,  C_MEMRD);
        add(0, LW,  1, 4'd4,  C_MEMWB);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].mr);
            check($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("row%0d_ctrl", i), 32'(got_ctrl()), 32'(vecs[i].ctrl));
            @(negedge clk);
        end

        // Reset asserted mid-MEMWRITE with memory still busy.
        drive(0, SW, 1); check("rst_seq_fetch", 32'(state), 32'd0);
        @(negedge clk);
        drive(0, SW, 1); check("rst_seq_decode", 32'(state), 32'd1);
        @(negedge clk);
        drive(0, SW, 0); check("rst_seq_memadr", 32'(state), 32'd2);
        @(negedge clk);
        drive(0, SW, 0); check("rst_seq_memwrite", 32'(state), 32'd5);
        check("rst_seq_mw_before", 32'(mem_write), 32'd1);
        @(negedge clk);
        drive(1, SW, 0);
        check("rst_seq_ctrl_in_reset", 32'(got_ctrl()), 32'(C_RST));
        @(negedge clk);
        drive(0, SW, 0);
        check("rst_seq_state_after", 32'(state), 32'd0);
        check("rst_seq_mw_after", 32'(mem_write), 32'd0);
        check("rst_seq_ctrl_after", 32'(got_ctrl()), 32'(C_FETCH0));
        @(negedge clk);
        drive(0, SW, 0);
        check("rst_seq_fetch_hold", 32'(state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
